// File: rtl/bcd_sequence_ctrl.sv
// Round-robin B/V run sequencer: times each granted run as a two-digit BCD count,
// one count per PRESCALE clocks. Faults freeze the count until acknowledged.
//   state   | meaning
//   S_IDLE  | no grant; arbitrate pending requests
//   S_RUN_B | B granted; counting toward effective preset_b
//   S_RUN_V | V granted; counting toward effective preset_v
//   S_DONE  | one-cycle completion, count held
//   S_FAULT | grants removed, count and prescaler frozen
module bcd_sequence_ctrl #(
  parameter int PRESCALE = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       Bs_req,
  input  logic       Vs_req,
  input  logic [7:0] preset_b,
  input  logic [7:0] preset_v,
  input  logic       Error,
  input  logic       fault_clr,
  output logic [7:0] bcd,
  output logic       Bs,
  output logic       Vs,
  output logic       done,
  output logic       fault
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_B, S_RUN_V, S_DONE, S_FAULT
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [7:0]      r_bcd, w_bcd_nxt;
  logic            r_last_v, w_last_v_nxt;
  logic            r_bs, r_vs, r_done, r_fault;
  logic [7:0]      w_eff_b, w_eff_v, w_eff_act;
  logic            w_req_act, w_tick;

  function automatic logic [7:0] bcd_sat(input logic [7:0] p);
    logic [3:0] t, u;
    t = (p[7:4] > 4'd9) ? 4'd9 : p[7:4];
    u = (p[3:0] > 4'd9) ? 4'd9 : p[3:0];
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  assign w_eff_b   = bcd_sat(preset_b);
  assign w_eff_v   = bcd_sat(preset_v);
  assign w_req_act = (r_state == S_RUN_B) ? Bs_req : Vs_req;
  assign w_eff_act = (r_state == S_RUN_B) ? w_eff_b : w_eff_v;
  assign w_tick    = (r_presc == PRESC_TC);

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_bcd_nxt    = r_bcd;
    w_last_v_nxt = r_last_v;
    if (Error) begin
      w_state_nxt = S_FAULT;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Tie goes to whoever was not served last.
          if (Bs_req && (!Vs_req || r_last_v)) begin
            w_state_nxt  = S_RUN_B;
            w_last_v_nxt = 1'b0;
            w_bcd_nxt    = 8'h00;
            w_presc_nxt  = '0;
          end else if (Vs_req) begin
            w_state_nxt  = S_RUN_V;
            w_last_v_nxt = 1'b1;
            w_bcd_nxt    = 8'h00;
            w_presc_nxt  = '0;
          end
        end
        S_RUN_B, S_RUN_V: begin
          if (!w_req_act) begin
            w_state_nxt = S_IDLE;
            w_bcd_nxt   = 8'h00;
            w_presc_nxt = '0;
          end else if (r_bcd == w_eff_act) begin
            w_state_nxt = S_DONE;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            w_bcd_nxt   = bcd_inc(r_bcd);
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) begin
            w_state_nxt = S_IDLE;
            w_bcd_nxt   = 8'h00;
            w_presc_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_bcd    <= 8'h00;
      r_last_v <= 1'b1;
      r_bs     <= 1'b0;
      r_vs     <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_bcd    <= w_bcd_nxt;
      r_last_v <= w_last_v_nxt;
      r_bs     <= (w_state_nxt == S_RUN_B);
      r_vs     <= (w_state_nxt == S_RUN_V);
      r_done   <= (w_state_nxt == S_DONE);
      r_fault  <= (w_state_nxt == S_FAULT);
    end
  end

  assign bcd   = r_bcd;
  assign Bs    = r_bs;
  assign Vs    = r_vs;
  assign done  = r_done;
  assign fault = r_fault;

endmodule

// File: tb/tb_bcd_sequence_ctrl.sv
// Bench for bcd_sequence_ctrl: directed scenarios plus random traffic, every cycle
// compared against a decimal-count reference model.
module tb_bcd_sequence_ctrl;

  localparam int PRE = 4;
  localparam int M_IDLE = 0, M_RUNB = 1, M_RUNV = 2, M_DONE = 3, M_FAULT = 4;

  logic       clock, reset_n, Bs_req, Vs_req, Error, fault_clr;
  logic [7:0] preset_b, preset_v;
  logic [7:0] bcd;
  logic       Bs, Vs, done, fault;

  int n_checks = 0, n_fail = 0;
  int m_mode, m_cycles;
  bit m_last_v;
  int bs_cnt, done_cnt, g_cnt;
  logic [3:0] g_order;
  logic prev_bs, prev_vs;
  logic [7:0] prev_bcd;
  bit saw_carry;

  bcd_sequence_ctrl #(.PRESCALE(PRE)) dut (
    .clock(clock), .reset_n(reset_n), .Bs_req(Bs_req), .Vs_req(Vs_req),
    .preset_b(preset_b), .preset_v(preset_v), .Error(Error), .fault_clr(fault_clr),
    .bcd(bcd), .Bs(Bs), .Vs(Vs), .done(done), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff(input logic [7:0] p);
    int t, u;
    t = (p[7:4] > 4'd9) ? 9 : int'(p[7:4]);
    u = (p[3:0] > 4'd9) ? 9 : int'(p[3:0]);
    return t * 10 + u;
  endfunction

  function automatic logic [7:0] exp_bcd();
    int c;
    c = (m_cycles / PRE) % 100;
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [7:0] rnd_preset();
    logic [7:0] p;
    p[3:0] = 4'($urandom_range(0, 15));
    p[7:4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cycles = 0;
    m_last_v = 1'b1;
  endtask

  task automatic model_step();
    bit req;
    int tgt;
    if (Error) begin
      m_mode = M_FAULT;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (Bs_req && (!Vs_req || m_last_v)) begin
          m_mode = M_RUNB; m_last_v = 1'b0; m_cycles = 0;
        end else if (Vs_req) begin
          m_mode = M_RUNV; m_last_v = 1'b1; m_cycles = 0;
        end
      end
      M_RUNB, M_RUNV: begin
        req = (m_mode == M_RUNB) ? Bs_req : Vs_req;
        tgt = eff((m_mode == M_RUNB) ? preset_b : preset_v);
        if (!req) begin
          m_mode = M_IDLE; m_cycles = 0;
        end else if ((m_cycles / PRE) % 100 == tgt) begin
          m_mode = M_DONE;
        end else begin
          m_cycles++;
        end
      end
      M_DONE: m_mode = M_IDLE;
      default: if (fault_clr) begin m_mode = M_IDLE; m_cycles = 0; end
    endcase
  endtask

  task automatic chk_outputs();
    logic [11:0] e;
    e = {exp_bcd(), m_mode == M_RUNB, m_mode == M_RUNV, m_mode == M_DONE, m_mode == M_FAULT};
    chk("outputs", {20'h0, bcd, Bs, Vs, done, fault}, {20'h0, e});
    chk("grant_excl", {31'h0, Bs & Vs}, 32'h0);
  endtask

  task automatic clear_stats();
    bs_cnt = 0; done_cnt = 0; g_cnt = 0; g_order = 4'h0;
    prev_bs = Bs; prev_vs = Vs; prev_bcd = bcd; saw_carry = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    if (!reset_n) model_reset();
    else model_step();
    chk_outputs();
    if (Bs) bs_cnt++;
    if (done) done_cnt++;
    if (Bs && !prev_bs) begin g_order = {g_order[2:0], 1'b1}; g_cnt++; end
    if (Vs && !prev_vs) begin g_order = {g_order[2:0], 1'b0}; g_cnt++; end
    if (prev_bcd == 8'h09 && bcd == 8'h10) saw_carry = 1'b1;
    prev_bs = Bs; prev_vs = Vs; prev_bcd = bcd;
  endtask

  task automatic wait_done(input int maxc);
    int i = 0;
    while (done !== 1'b1 && i < maxc) begin cyc(); i++; end
    chk("wait_done", {31'h0, done}, 32'h1);
  endtask

  task automatic wait_bcd(input logic [7:0] v, input int maxc);
    int i = 0;
    while (bcd !== v && i < maxc) begin cyc(); i++; end
    chk("wait_bcd", {24'h0, bcd}, {24'h0, v});
  endtask

  // Assert reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async", {20'h0, bcd, Bs, Vs, done, fault}, 32'h0);
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; Bs_req = 0; Vs_req = 0; Error = 0; fault_clr = 0;
    preset_b = 8'h00; preset_v = 8'h00;
    model_reset();
    clear_stats();
    repeat (3) cyc();
    chk("rst_init", {20'h0, bcd, Bs, Vs, done, fault}, 32'h0);
    reset_n = 1'b1;

    // B run, preset 03
    preset_b = 8'h03; Bs_req = 1'b1;
    clear_stats();
    wait_done(40);
    Bs_req = 1'b0;
    cyc();
    chk("s1_bs_cycles", bs_cnt, 13);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_idle_bs", {31'h0, Bs}, 32'h0);

    // Round-robin from reset
    async_reset();
    preset_b = 8'h01; preset_v = 8'h01; Bs_req = 1'b1; Vs_req = 1'b1;
    clear_stats();
    for (int i = 0; i < 60 && done_cnt < 4; i++) cyc();
    chk("s2_done_cnt", done_cnt, 4);
    chk("s2_grants", g_cnt, 4);
    chk("s2_order", {28'h0, g_order}, 32'hA);
    Bs_req = 1'b0; Vs_req = 1'b0;
    cyc(); cyc();

    // V run through the units carry
    preset_v = 8'h19; Vs_req = 1'b1;
    clear_stats();
    wait_done(100);
    chk("s3_final", {24'h0, bcd}, 32'h19);
    chk("s3_carry", {31'h0, saw_carry}, 32'h1);
    Vs_req = 1'b0;
    cyc();

    // Fault mid-run, blocked clear, then release
    preset_b = 8'h05; Bs_req = 1'b1;
    wait_bcd(8'h02, 30);
    Error = 1'b1;
    cyc();
    chk("s4_fault", {31'h0, fault}, 32'h1);
    chk("s4_bs", {31'h0, Bs}, 32'h0);
    chk("s4_bcd", {24'h0, bcd}, 32'h02);
    fault_clr = 1'b1;
    cyc();
    chk("s4_noexit", {31'h0, fault}, 32'h1);
    fault_clr = 1'b0; Error = 1'b0;
    cyc();
    Bs_req = 1'b0; fault_clr = 1'b1;
    cyc();
    chk("s4_exit", {31'h0, fault}, 32'h0);
    chk("s4_bcd0", {24'h0, bcd}, 32'h00);
    fault_clr = 1'b0;
    cyc();

    // Abort by dropping request
    preset_b = 8'h07; Bs_req = 1'b1;
    clear_stats();
    wait_bcd(8'h04, 40);
    Bs_req = 1'b0;
    cyc();
    chk("s5_abort_bs", {31'h0, Bs}, 32'h0);
    chk("s5_abort_bcd", {24'h0, bcd}, 32'h00);
    repeat (3) cyc();
    chk("s5_nodone", done_cnt, 0);

    // Saturated preset
    preset_b = 8'hFA; Bs_req = 1'b1;
    wait_done(450);
    chk("s6_final", {24'h0, bcd}, 32'h99);
    Bs_req = 1'b0;
    cyc();

    // Reset mid-run, then tie goes to B
    preset_b = 8'h09; Bs_req = 1'b1;
    wait_bcd(8'h05, 40);
    async_reset();
    preset_b = 8'h00; preset_v = 8'h00; Bs_req = 1'b1; Vs_req = 1'b1;
    cyc();
    chk("s7_tie_b", {30'h0, Bs, Vs}, 32'h2);
    Bs_req = 1'b0; Vs_req = 1'b0;
    cyc(); cyc();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) Bs_req = ~Bs_req;
      if ($urandom_range(0, 29) == 0) Vs_req = ~Vs_req;
      Error = ($urandom_range(0, 59) == 0);
      fault_clr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) preset_b = rnd_preset();
      if ($urandom_range(0, 49) == 0) preset_v = rnd_preset();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
